// File: rtl/fpmult_pkg.sv
// Shared types and helpers for the pipelined fixed-point multiplier.
// Build option: FPMULT_ROUND_EN selects round-half-up instead of truncation.
package fpmult_pkg;

    localparam int LATENCY = 3;
    localparam int DW      = 64;

    typedef struct packed {
        logic          vld;
        logic          ovf;
        logic [DW-1:0] data;
    } stage_t;

    function automatic logic [DW-1:0] sat_max(input int wio, input int wfo);
        sat_max = (DW'(1) << (wio + wfo - 1)) - DW'(1);
    endfunction

    function automatic logic [DW-1:0] sat_min(input int wio, input int wfo);
        sat_min = DW'(1) << (wio + wfo - 1);
    endfunction

endpackage

// File: rtl/fpmult_if.sv
// Operand/result handshake bundle for fpmult_pipe.
// master = source/sink side, slave = multiplier side.
interface fpmult_if #(
    parameter int WI1 = 4,
    parameter int WF1 = 4,
    parameter int WI2 = 4,
    parameter int WF2 = 4,
    parameter int WIO = 4,
    parameter int WFO = 4
);
    logic                      IN_VALID;
    logic                      IN_READY;
    logic signed [WI1+WF1-1:0] IN1;
    logic signed [WI2+WF2-1:0] IN2;
    logic                      OUT_VALID;
    logic                      OUT_READY;
    logic [WIO+WFO-1:0]        OUT;
    logic                      OVF;
    logic                      OVF_STICKY;
    logic                      CLR_STICKY;

    modport master (
        output IN_VALID, IN1, IN2, OUT_READY, CLR_STICKY,
        input  IN_READY, OUT_VALID, OUT, OVF, OVF_STICKY
    );

    modport slave (
        input  IN_VALID, IN1, IN2, OUT_READY, CLR_STICKY,
        output IN_READY, OUT_VALID, OUT, OVF, OVF_STICKY
    );
endinterface

// File: rtl/fpmult_fmt.sv
// Product-to-output conversion: round/truncate, resize and saturate.
// Build option: FPMULT_ROUND_EN adds half an output LSB before dropping bits.
module fpmult_fmt
    import fpmult_pkg::*;
#(
    parameter int WIP = 8,
    parameter int WFP = 8,
    parameter int WIO = 4,
    parameter int WFO = 4
) (
    input  logic signed [WIP+WFP-1:0] p_i,
    output logic [WIO+WFO-1:0]        out_o,
    output logic                      ovf_o
);
    localparam int WP = WIP + WFP;
    localparam int WE = WP + 1;
    localparam int WQ = WIP + 1 + WFO;
    localparam int WO = WIO + WFO;

    logic signed [WE-1:0] pe;
    logic signed [WQ-1:0] q;

    assign pe = WE'(p_i);

    generate
        if (WFO >= WFP) begin : g_ext
            assign q = WQ'(pe) <<< (WFO - WFP);
        end else begin : g_drop
            localparam int D = WFP - WFO;
            logic signed [WE-1:0] sum;
`ifdef FPMULT_ROUND_EN
            localparam logic [WE-1:0] HALF = WE'(1) << (D - 1);
            assign sum = pe + $signed(HALF);
`else
            assign sum = pe;
`endif
            assign q = WQ'(sum >>> D);
        end

        if (WO >= WQ) begin : g_wide
            assign out_o = WO'(q);
            assign ovf_o = 1'b0;
        end else begin : g_narrow
            localparam int K = WQ - WO + 1;
            localparam logic [DW-1:0] MAXC = sat_max(WIO, WFO);
            localparam logic [DW-1:0] MINC = sat_min(WIO, WFO);
            logic [K-1:0] top;
            assign top = q[WQ-1:WO-1];
            // Discarded bits plus the new sign must all agree to fit
            always_comb begin
                out_o = q[WO-1:0];
                ovf_o = 1'b0;
                if (top != '0 && top != '1) begin
                    ovf_o = 1'b1;
                    out_o = q[WQ-1] ? MINC[WO-1:0] : MAXC[WO-1:0];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/fpmult_pipe.sv
// Three-stage signed fixed-point multiplier with valid/ready flow control.
// Build option: FPMULT_ROUND_EN (see fpmult_fmt).
module fpmult_pipe
    import fpmult_pkg::*;
#(
    parameter int WI1 = 4,
    parameter int WF1 = 4,
    parameter int WI2 = 4,
    parameter int WF2 = 4,
    parameter int WIO = 4,
    parameter int WFO = 4
) (
    input logic     CLK,
    input logic     RESET,
    fpmult_if.slave bus
);
    localparam int WA  = WI1 + WF1;
    localparam int WB  = WI2 + WF2;
    localparam int WIP = WI1 + WI2;
    localparam int WFP = WF1 + WF2;
    localparam int WP  = WIP + WFP;
    localparam int WO  = WIO + WFO;

    logic                 en;
    logic                 s1_vld_q, s1_vld_d;
    logic signed [WA-1:0] s1_a_q, s1_a_d;
    logic signed [WB-1:0] s1_b_q, s1_b_d;
    stage_t               s2_q, s2_d;
    stage_t               s3_q, s3_d;
    logic                 sticky_q, sticky_d;
    logic signed [WP-1:0] prod;
    logic signed [WP-1:0] p2;
    logic [WO-1:0]        fmt_out;
    logic                 fmt_ovf;
    logic                 unused_bits;

    // Whole pipe moves together; a stalled output freezes bubbles too
    assign en           = ~s3_q.vld | bus.OUT_READY;
    assign bus.IN_READY = en & ~RESET;

    assign prod = WP'(s1_a_q) * WP'(s1_b_q);
    assign p2   = s2_q.data[WP-1:0];

    fpmult_fmt #(
        .WIP (WIP),
        .WFP (WFP),
        .WIO (WIO),
        .WFO (WFO)
    ) u_fmt (
        .p_i   (p2),
        .out_o (fmt_out),
        .ovf_o (fmt_ovf)
    );

    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s2_d     = s2_q;
        s3_d     = s3_q;
        if (en) begin
            s1_vld_d    = bus.IN_VALID;
            s1_a_d      = bus.IN1;
            s1_b_d      = bus.IN2;
            s2_d.vld    = s1_vld_q;
            s2_d.ovf    = 1'b0;
            s2_d.data   = DW'(prod);
            s3_d.vld    = s2_q.vld;
            if (s2_q.vld) begin
                s3_d.data = DW'(fmt_out);
                s3_d.ovf  = fmt_ovf;
            end
        end
    end

    // A set on the transfer edge overrides a simultaneous clear
    always_comb begin
        sticky_d = sticky_q;
        if (bus.CLR_STICKY)
            sticky_d = 1'b0;
        if (s3_q.vld & bus.OUT_READY & s3_q.ovf)
            sticky_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_vld_q <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            sticky_q <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.OUT_VALID  = s3_q.vld;
    assign bus.OUT        = s3_q.data[WO-1:0];
    assign bus.OVF        = s3_q.ovf;
    assign bus.OVF_STICKY = sticky_q;

    assign unused_bits = ^{s2_q, s3_q};

endmodule

// File: tb/tb_fpmult_pipe.sv
// Scoreboard bench for fpmult_pipe, Q4.4 x Q4.4 -> Q4.4.
// Expected values come from an integer model honouring FPMULT_ROUND_EN.
module tb_fpmult_pipe;
    import fpmult_pkg::*;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    logic [8:0] exp_q[$];

    fpmult_if bus ();

    fpmult_pipe dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b);
        int sa, sb, p, r, q;
        sa = $signed(a);
        sb = $signed(b);
        p  = sa * sb;
`ifdef FPMULT_ROUND_EN
        p = p + 8;
`endif
        r = p % 16;
        if (r < 0) r = r + 16;
        q = (p - r) / 16;
        if (q > 127)  return {1'b1, 8'h7F};
        if (q < -128) return {1'b1, 8'h80};
        return {1'b0, q[7:0]};
    endfunction

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (bus.IN_READY !== 1'b0) begin
            failures++; $display("FAIL rst_in_ready: got %b expected 0", bus.IN_READY);
        end
        checks++;
        if (bus.OUT_VALID !== 1'b0) begin
            failures++; $display("FAIL rst_out_valid: got %b expected 0", bus.OUT_VALID);
        end
        checks++;
        if (bus.OUT !== 8'h00) begin
            failures++; $display("FAIL rst_out: got %h expected 00", bus.OUT);
        end
        checks++;
        if (bus.OVF !== 1'b0) begin
            failures++; $display("FAIL rst_ovf: got %b expected 0", bus.OVF);
        end
        checks++;
        if (bus.OVF_STICKY !== 1'b0) begin
            failures++; $display("FAIL rst_sticky: got %b expected 0", bus.OVF_STICKY);
        end
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.IN_READY !== 1'b1) begin
            failures++; $display("FAIL post_rst_in_ready: got %b expected 1", bus.IN_READY);
        end
    endtask

    task automatic test_basic();
        int n;
        logic [8:0] e;
        @(posedge CLK); #1;
        bus.OUT_READY = 1'b1;
        bus.IN_VALID  = 1'b1;
        bus.IN1 = 8'h18;
        bus.IN2 = 8'h20;
        exp_q.push_back(model(8'h18, 8'h20));
        n = 0;
        while (!bus.OUT_VALID && n < 10) begin
            @(posedge CLK); #1;
            bus.IN_VALID = 1'b0;
            n++;
        end
        checks++;
        if (n !== LATENCY) begin
            failures++; $display("FAIL basic_latency: got %0d expected %0d", n, LATENCY);
        end
        e = exp_q.pop_front();
        checks++;
        if ({bus.OVF, bus.OUT} !== e) begin
            failures++; $display("FAIL basic_value: got %h expected %h", {bus.OVF, bus.OUT}, e);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_saturation();
        int n;
        logic [8:0] e;
        bus.CLR_STICKY = 1'b0;
        bus.OUT_READY  = 1'b1;
        bus.IN_VALID   = 1'b1;
        bus.IN1 = 8'h40;
        bus.IN2 = 8'h40;
        exp_q.push_back(model(8'h40, 8'h40));
        n = 0;
        while (!bus.OUT_VALID && n < 10) begin
            @(posedge CLK); #1;
            bus.IN_VALID = 1'b0;
            n++;
        end
        e = exp_q.pop_front();
        checks++;
        if ({bus.OVF, bus.OUT} !== e) begin
            failures++; $display("FAIL sat_pos: got %h expected %h", {bus.OVF, bus.OUT}, e);
        end
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++;
        if (bus.OVF_STICKY !== 1'b1) begin
            failures++; $display("FAIL sticky_set: got %b expected 1", bus.OVF_STICKY);
        end
        @(posedge CLK); #1;
        bus.CLR_STICKY = 1'b1;
        @(posedge CLK); #1;
        bus.CLR_STICKY = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.OVF_STICKY !== 1'b0) begin
            failures++; $display("FAIL sticky_clr: got %b expected 0", bus.OVF_STICKY);
        end
        @(posedge CLK); #1;
        bus.CLR_STICKY = 1'b1;
        bus.IN_VALID   = 1'b1;
        exp_q.push_back(model(8'h40, 8'h40));
        n = 0;
        while (!bus.OUT_VALID && n < 10) begin
            @(posedge CLK); #1;
            bus.IN_VALID = 1'b0;
            n++;
        end
        e = exp_q.pop_front();
        checks++;
        if ({bus.OVF, bus.OUT} !== e) begin
            failures++; $display("FAIL sat_pos2: got %h expected %h", {bus.OVF, bus.OUT}, e);
        end
        @(posedge CLK); #1;
        bus.CLR_STICKY = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.OVF_STICKY !== 1'b1) begin
            failures++; $display("FAIL sticky_set_wins: got %b expected 1", bus.OVF_STICKY);
        end
    endtask

    task automatic test_corners();
        logic [7:0] a[5] = '{8'h80, 8'h80, 8'h80, 8'h01, 8'hFF};
        logic [7:0] b[5] = '{8'h10, 8'h80, 8'h20, 8'h08, 8'h08};
        logic [8:0] e;
        int sent = 0;
        int got  = 0;
        for (int c = 0; c < 60 && got < 5; c++) begin
            @(posedge CLK); #1;
            bus.OUT_READY = 1'b1;
            bus.IN_VALID  = (sent < 5);
            if (sent < 5) begin
                bus.IN1 = a[sent];
                bus.IN2 = b[sent];
            end
            @(negedge CLK);
            if (bus.OUT_VALID && bus.OUT_READY) begin
                e = exp_q.pop_front();
                checks++;
                if ({bus.OVF, bus.OUT} !== e) begin
                    failures++;
                    $display("FAIL corner_%0d: got %h expected %h", got, {bus.OVF, bus.OUT}, e);
                end
                got++;
            end
            if (bus.IN_VALID && bus.IN_READY) begin
                exp_q.push_back(model(a[sent], b[sent]));
                sent++;
            end
        end
        checks++;
        if (got !== 5) begin
            failures++; $display("FAIL corner_count: got %0d expected 5", got);
            exp_q.delete();
        end
        @(posedge CLK); #1;
        bus.IN_VALID = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] a[8];
        logic [7:0] b[8];
        logic [8:0] e, held;
        bit hold = 1'b0;
        int sent = 0;
        int got  = 0;
        for (int i = 0; i < 8; i++) begin
            a[i] = 8'($urandom_range(0, 255));
            b[i] = 8'($urandom_range(0, 255));
        end
        held = '0;
        for (int c = 0; c < 300 && got < 8; c++) begin
            @(posedge CLK); #1;
            bus.OUT_READY = 1'($urandom_range(0, 1));
            bus.IN_VALID  = (sent < 8);
            if (sent < 8) begin
                bus.IN1 = a[sent];
                bus.IN2 = b[sent];
            end
            @(negedge CLK);
            if (hold && bus.OUT_VALID) begin
                checks++;
                if ({bus.OVF, bus.OUT} !== held) begin
                    failures++;
                    $display("FAIL bp_stable: got %h expected %h", {bus.OVF, bus.OUT}, held);
                end
            end
            hold = bus.OUT_VALID && !bus.OUT_READY;
            held = {bus.OVF, bus.OUT};
            if (bus.OUT_VALID && bus.OUT_READY) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL bp_extra: got %h expected none", {bus.OVF, bus.OUT});
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.OVF, bus.OUT} !== e) begin
                        failures++;
                        $display("FAIL bp_%0d: got %h expected %h", got, {bus.OVF, bus.OUT}, e);
                    end
                end
                got++;
            end
            if (bus.IN_VALID && bus.IN_READY) begin
                exp_q.push_back(model(a[sent], b[sent]));
                sent++;
            end
        end
        checks++;
        if (got !== 8 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_count: got %0d left %0d expected 8 left 0", got, exp_q.size());
            exp_q.delete();
        end
        @(posedge CLK); #1;
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] a[8];
        logic [7:0] b[8];
        logic [8:0] e;
        int sent  = 0;
        int got   = 0;
        int first = -1;
        int last  = -1;
        for (int i = 0; i < 8; i++) begin
            a[i] = 8'($urandom_range(0, 255));
            b[i] = 8'(i * 16 + 3);
        end
        for (int c = 0; c < 60 && got < 8; c++) begin
            @(posedge CLK); #1;
            bus.OUT_READY = 1'b1;
            bus.IN_VALID  = (sent < 8);
            if (sent < 8) begin
                bus.IN1 = a[sent];
                bus.IN2 = b[sent];
            end
            @(negedge CLK);
            if (bus.OUT_VALID) begin
                if (first < 0) first = c;
                last = c;
                e = exp_q.pop_front();
                checks++;
                if ({bus.OVF, bus.OUT} !== e) begin
                    failures++;
                    $display("FAIL b2b_%0d: got %h expected %h", got, {bus.OVF, bus.OUT}, e);
                end
                got++;
            end
            if (bus.IN_VALID && bus.IN_READY) begin
                exp_q.push_back(model(a[sent], b[sent]));
                sent++;
            end
        end
        checks++;
        if (got !== 8 || (last - first) !== 7) begin
            failures++;
            $display("FAIL b2b_span: got %0d results over %0d cycles expected 8 over 8",
                     got, last - first + 1);
            exp_q.delete();
        end
        @(posedge CLK); #1;
        bus.IN_VALID = 1'b0;
    endtask

    task automatic test_reset_midstream();
        int n;
        int seen = 0;
        logic [8:0] e;
        bus.OUT_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.IN_VALID = 1'b1;
            bus.IN1 = 8'(8'h18 + i);
            bus.IN2 = 8'h20;
            @(posedge CLK); #1;
        end
        bus.IN_VALID = 1'b0;
        checks++;
        if (bus.OUT_VALID !== 1'b1) begin
            failures++; $display("FAIL mid_full: got %b expected 1", bus.OUT_VALID);
        end
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (bus.OUT_VALID !== 1'b0) begin
            failures++; $display("FAIL mid_out_valid: got %b expected 0", bus.OUT_VALID);
        end
        checks++;
        if (bus.OUT !== 8'h00 || bus.OVF !== 1'b0) begin
            failures++; $display("FAIL mid_out: got %h/%b expected 00/0", bus.OUT, bus.OVF);
        end
        RESET = 1'b0;
        bus.OUT_READY = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (bus.OUT_VALID) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++; $display("FAIL mid_flushed: got %0d outputs expected 0", seen);
        end
        @(posedge CLK); #1;
        bus.IN_VALID = 1'b1;
        bus.IN1 = 8'hE8;
        bus.IN2 = 8'h30;
        exp_q.push_back(model(8'hE8, 8'h30));
        n = 0;
        while (!bus.OUT_VALID && n < 10) begin
            @(posedge CLK); #1;
            bus.IN_VALID = 1'b0;
            n++;
        end
        checks++;
        if (n !== LATENCY) begin
            failures++; $display("FAIL mid_latency: got %0d expected %0d", n, LATENCY);
        end
        e = exp_q.pop_front();
        checks++;
        if ({bus.OVF, bus.OUT} !== e) begin
            failures++; $display("FAIL mid_value: got %h expected %h", {bus.OVF, bus.OUT}, e);
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        bus.IN_VALID   = 1'b0;
        bus.IN1        = '0;
        bus.IN2        = '0;
        bus.OUT_READY  = 1'b0;
        bus.CLR_STICKY = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_corners();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
